// File: rtl/mult_arbiter_if.sv
// Request/response and shared-multiplier bundle for mult_arbiter.
// 'slave' is the arbiter side; 'master' is the environment (requesters, sink, multiplier).
interface mult_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_ops;
    logic [31:0] req1_ops;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [7:0]  resp_data;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [7:0]  m_c;
    logic [7:0]  m_d;
    logic [3:0]  m_en;
    logic [7:0]  m_result;
    logic        busy;

    modport slave (
        input  req_valid, req0_ops, req1_ops, resp_ready, m_result,
        output req_ready, resp_valid, resp_id, resp_data,
               m_a, m_b, m_c, m_d, m_en, busy
    );

    modport master (
        output req_valid, req0_ops, req1_ops, resp_ready, m_result,
        input  req_ready, resp_valid, resp_id, resp_data,
               m_a, m_b, m_c, m_d, m_en, busy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared pipelined multiplier computing a*b+c*d.
// One operation in flight; the result is sampled LAT cycles after the issue cycle.
module mult_arbiter #(
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t     state, state_nx;
    logic       rr;
    logic [3:0] cnt;
    logic       gnt_id;
    logic       hs;

    // Grant is only offered from IDLE, so a handshake can never overlap a response accept.
    always_comb begin
        gnt_id        = 1'b0;
        bus.req_ready = 2'b00;
        case (bus.req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = rr;
            default: gnt_id = 1'b0;
        endcase
        if (state == IDLE && !rst && |bus.req_valid)
            bus.req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    assign hs = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.m_en       = 4'b0000;
        bus.resp_valid = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE:  if (hs) state_nx = ISSUE;
            ISSUE: begin
                bus.m_en = 4'b1111;
                state_nx = WAIT;
            end
            WAIT:  if (cnt == 4'd0) state_nx = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand registers double as the multiplier inputs, so they are stable from ISSUE onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr            <= 1'b0;
            cnt           <= 4'd0;
            bus.resp_id   <= 1'b0;
            bus.resp_data <= 8'd0;
            bus.m_a       <= 8'd0;
            bus.m_b       <= 8'd0;
            bus.m_c       <= 8'd0;
            bus.m_d       <= 8'd0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    {bus.m_a, bus.m_b, bus.m_c, bus.m_d} <= gnt_id ? bus.req1_ops : bus.req0_ops;
                    bus.resp_id <= gnt_id;
                    rr          <= ~gnt_id;
                end
                ISSUE: cnt <= CNT_LOAD;
                WAIT: begin
                    if (cnt == 4'd0) bus.resp_data <= bus.m_result;
                    else             cnt           <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
